// File: rtl/mem_boot_ctrl_pkg.sv
// mem_boot_ctrl_pkg: shared widths, mode/state encodings and LFSR step for the boot controller
package mem_boot_ctrl_pkg;
  localparam int REG_WIDTH = 32;
  localparam int ADDR_WIDTH = 16;
  localparam int MEM_DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [REG_WIDTH-1:0] LFSR_TAPS = 32'h8020_0003;
  typedef enum logic [1:0] {
    MODE_ZERO       = 2'b00,
    MODE_RAND       = 2'b01,
    MODE_CONST      = 2'b10,
    MODE_CLEAR_RAND = 2'b11
  } mode_e;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FILL,
    S_RUN,
    S_DUMP,
    S_DONE
  } state_e;
  function automatic logic [REG_WIDTH-1:0] lfsr_next(input logic [REG_WIDTH-1:0] v);
    return {1'b0, v[REG_WIDTH-1:1]} ^ (v[0] ? LFSR_TAPS : '0);
  endfunction
endpackage

// File: rtl/mem_boot_ctrl_lfsr32.sv
// lfsr32: 32-bit Galois LFSR, reloaded from seed only on reset
//   clk, reset  : clock, synchronous active-high reset
//   seed        : reload value (0 is replaced by 1 so the register never locks up)
//   advance     : step once this cycle
//   value       : current LFSR state
module lfsr32 (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] seed,
  input  logic        advance,
  output logic [31:0] value
);
  import mem_boot_ctrl_pkg::*;
  always_ff @(posedge clk) begin
    if (reset) value <= (seed == '0) ? 32'd1 : seed;
    else if (advance) value <= lfsr_next(value);
  end
endmodule

// File: rtl/mem_boot_ctrl.sv
// mem_boot_ctrl: clears/fills memory, releases the CPU for a while, then dumps a range back out
//   start/mode/range_*/fill_value/run_cycles/dump_* : sequence request, latched on start in IDLE/DONE
//   mem_addr/mem_we/mem_wdata/mem_rdata             : memory port, one-cycle read latency
//   cpu_reset_n                                     : high only while the CPU runs
//   busy/done/error, dump_valid/dump_addr/dump_data : status and readback stream
module mem_boot_ctrl #(
  parameter int          ADDR_WIDTH = 16,
  parameter int          DATA_WIDTH = 8,
  parameter int          DEPTH      = 2 ** ADDR_WIDTH,
  parameter logic [31:0] SEED       = 32'h0000_0001
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic [ADDR_WIDTH-1:0] range_lo,
  input  logic [ADDR_WIDTH-1:0] range_hi,
  input  logic [DATA_WIDTH-1:0] fill_value,
  input  logic [15:0]           run_cycles,
  input  logic [ADDR_WIDTH-1:0] dump_lo,
  input  logic [ADDR_WIDTH-1:0] dump_hi,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  cpu_reset_n,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic                  dump_valid,
  output logic [ADDR_WIDTH-1:0] dump_addr,
  output logic [DATA_WIDTH-1:0] dump_data
);
  import mem_boot_ctrl_pkg::*;
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(DEPTH - 1);
  state_e state_q, state_d;
  mode_e mode_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, rlo_q, rhi_q, dlo_q, dhi_q, daddr_q;
  logic [DATA_WIDTH-1:0] fill_q, fdata;
  logic [15:0] cnt_q, cnt_d;
  logic last_q, last_d, err_q, err_d, dv_q;
  logic take, bad, rnd;
  logic [31:0] lfsr_val;
  logic unused_lfsr;
  assign take = start && (state_q == S_IDLE || state_q == S_DONE);
  assign bad = (range_lo > range_hi) || (dump_lo > dump_hi) ||
               (32'(range_hi) >= 32'(DEPTH)) || (32'(dump_hi) >= 32'(DEPTH));
  assign rnd = (mode_q == MODE_RAND) || (mode_q == MODE_CLEAR_RAND);
  assign unused_lfsr = ^lfsr_val;
  lfsr32 u_lfsr (
    .clk    (clk),
    .reset  (reset),
    .seed   (SEED),
    .advance(state_q == S_FILL && rnd),
    .value  (lfsr_val)
  );
  assign fdata = (mode_q == MODE_CONST) ? fill_q : rnd ? lfsr_val[DATA_WIDTH-1:0] : '0;
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_DONE: if (take) begin
        err_d   = bad;
        last_d  = 1'b0;
        cnt_d   = run_cycles;
        addr_d  = (mode == MODE_CLEAR_RAND) ? '0 : range_lo;
        state_d = bad ? S_DONE : (mode == MODE_CLEAR_RAND) ? S_CLEAR : S_FILL;
      end
      S_CLEAR: begin
        addr_d  = (addr_q == LAST) ? rlo_q : addr_q + 1'b1;
        state_d = (addr_q == LAST) ? S_FILL : S_CLEAR;
      end
      S_FILL: begin
        addr_d  = (addr_q == rhi_q) ? dlo_q : addr_q + 1'b1;
        state_d = (addr_q != rhi_q) ? S_FILL : (cnt_q != '0) ? S_RUN : S_DUMP;
      end
      S_RUN: begin
        cnt_d   = cnt_q - 16'd1;
        state_d = (cnt_q == 16'd1) ? S_DUMP : S_RUN;
      end
      // one extra cycle after the last read lets its dump_valid land before DONE
      S_DUMP: begin
        state_d = last_q ? S_DONE : S_DUMP;
        last_d  = last_q || (addr_q == dhi_q);
        addr_d  = (last_q || addr_q == dhi_q) ? addr_q : addr_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      dv_q    <= 1'b0;
      daddr_q <= '0;
      mode_q  <= MODE_ZERO;
      rlo_q   <= '0;
      rhi_q   <= '0;
      dlo_q   <= '0;
      dhi_q   <= '0;
      fill_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
      dv_q    <= state_q == S_DUMP && !last_q;
      daddr_q <= (state_q == S_DUMP && !last_q) ? addr_q : daddr_q;
      if (take) begin
        mode_q <= mode_e'(mode);
        rlo_q  <= range_lo;
        rhi_q  <= range_hi;
        dlo_q  <= dump_lo;
        dhi_q  <= dump_hi;
        fill_q <= fill_value;
      end
    end
  end
  assign mem_addr    = addr_q;
  assign mem_we      = state_q == S_CLEAR || state_q == S_FILL;
  assign mem_wdata   = (state_q == S_FILL) ? fdata : '0;
  assign cpu_reset_n = state_q == S_RUN;
  assign busy        = mem_we || state_q == S_RUN || state_q == S_DUMP;
  assign done        = state_q == S_DONE;
  assign error       = err_q;
  assign dump_valid  = dv_q;
  assign dump_addr   = daddr_q;
  assign dump_data   = dv_q ? mem_rdata : '0;
endmodule

// File: doc/mem_boot_ctrl.md
MEM_BOOT_CTRL -- requirements
Module: mem_boot_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, memory address width.
REQ-002 Parameter DATA_WIDTH, default 8, memory word width (1..32).
REQ-003 Parameter DEPTH, default 2**ADDR_WIDTH, number of memory words.
REQ-004 Parameter SEED, default 32'h0000_0001, LFSR seed; 0 SHALL be replaced by 1.
REQ-005 Ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high.
REQ-006 start  in  1  one-cycle pulse, begins a sequence when idle.
REQ-007 mode  in  2  00 zero-fill, 01 random-fill, 10 constant-fill, 11 zero-all-then-random-range.
REQ-008 range_lo / range_hi  in  ADDR_WIDTH  inclusive fill range.
REQ-009 fill_value  in  DATA_WIDTH  constant for mode 10.
REQ-010 run_cycles  in  16  cycles the CPU runs after release.
REQ-011 dump_lo / dump_hi  in  ADDR_WIDTH  inclusive readback range.
REQ-012 mem_addr  out  ADDR_WIDTH; mem_we  out  1; mem_wdata  out  DATA_WIDTH; mem_rdata  in  DATA_WIDTH (one-cycle read latency).
REQ-013 cpu_reset_n  out  1  held-in-reset control for the CPU.
REQ-014 busy, done, error  out  1 each; dump_valid  out  1; dump_addr  out  ADDR_WIDTH; dump_data  out  DATA_WIDTH.

Function
REQ-015 States: IDLE, CLEAR, FILL, RUN, DUMP, DONE; start is ignored outside IDLE and DONE.
REQ-016 start in IDLE/DONE latches all range/mode/count inputs; the block uses only the latched copies until the next start.
REQ-017 range_lo > range_hi, dump_lo > dump_hi, or range_hi/dump_hi >= DEPTH at start SHALL set error, go to DONE in one cycle, and issue no writes.
REQ-018 Mode 11 SHALL enter CLEAR and write 0 to addresses 0..DEPTH-1, one per cycle, then enter FILL; modes 00/01/10 SHALL enter FILL directly.
REQ-019 FILL SHALL write one word per cycle from range_lo to range_hi inclusive, with mem_we high only during CLEAR/FILL.
REQ-020 FILL data: 0 (mode 00), fill_value (mode 10), LFSR low DATA_WIDTH bits (modes 01/11).
REQ-021 LFSR: 32-bit Galois, taps 32'h8020_0003, loaded with SEED on reset only, advanced once per random word written; sequences continue across runs.
REQ-022 cpu_reset_n SHALL be 0 from reset until FILL completes, then 1 for exactly run_cycles cycles in RUN; run_cycles=0 skips RUN.
REQ-023 Leaving RUN SHALL drive cpu_reset_n back to 0 and enter DUMP.
REQ-024 DUMP SHALL issue reads dump_lo..dump_hi one per cycle; each dump_valid pulse SHALL occur one cycle after its address, with dump_addr/dump_data matching it.
REQ-025 After the last dump_valid the block SHALL enter DONE, assert done, and hold it until the next start or reset.
REQ-026 busy SHALL be 1 in CLEAR, FILL, RUN, DUMP; 0 in IDLE and DONE.
REQ-027 Address counters SHALL not wrap: range_hi = DEPTH-1 terminates after writing DEPTH-1.

Reset
REQ-028 reset SHALL force IDLE on the next clk edge, aborting any state.
REQ-029 Reset values: cpu_reset_n 0, mem_we 0, busy 0, done 0, error 0, dump_valid 0, mem_addr 0, mem_wdata 0, dump_addr 0, dump_data 0, LFSR = SEED (or 1).
REQ-030 Reset asserted mid-FILL SHALL stop writes on the next cycle; partial memory contents are not restored.

Structure
REQ-031 Mode encodings, state enum and the LFSR tap constant SHALL live in the shared package beside REG_WIDTH/ADDR_WIDTH/MEM_DEPTH.
REQ-032 The LFSR SHALL be one sub-module, lfsr32, with ports clk, reset, seed, advance, value.

Verification
REQ-033 Mode 10, range 0x10..0x13, fill_value 0xA5, run_cycles 0, dump 0x10..0x13 -> four writes of A5 then four dump_valid pulses, each with data A5; done=1.
REQ-034 Mode 11, DEPTH=64, range 0..7, SEED 1 -> 64 zero writes, then 8 writes matching a reference LFSR model; addresses 8..63 read back 0.
REQ-035 run_cycles=5 -> cpu_reset_n high for exactly 5 cycles between the last FILL write and the first DUMP read.
REQ-036 range_lo=0x20, range_hi=0x1F -> error=1 and done=1 one cycle after start; mem_we never asserts.
REQ-037 reset asserted on the third FILL write of range 0..9 -> mem_we=0 next cycle, state IDLE, cpu_reset_n=0; a following start runs normally.
REQ-038 start pulsed during RUN -> ignored; the sequence completes with the original latched parameters.
